// File: rtl/sram_bridge_pkg.sv
// Shared state encoding, lane mapping and wait-count limit for the SRAM byte bridge.
package sram_bridge_pkg;

    localparam int MAX_WAIT = 15;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        RD,
        WR,
        HOLD,
        DONE
    } state_t;

    // Odd banks sit on the high byte lane of the 16-bit data bus.
    function automatic logic lane_hi(input logic [1:0] bank);
        return bank[0];
    endfunction

endpackage

// File: rtl/sram_lane_io.sv
// Byte-lane tristate driver for the 16-bit SRAM data bus; combinational, no backpressure.
module sram_lane_io (
    input  logic        lane_sel,
    input  logic        drive,
    input  logic [7:0]  wr_byte,
    output logic [7:0]  rd_byte,
    inout  wire  [15:0] sram_d
);

    assign sram_d[7:0]  = (drive && !lane_sel) ? wr_byte : 8'hzz;
    assign sram_d[15:8] = (drive &&  lane_sel) ? wr_byte : 8'hzz;

    assign rd_byte = lane_sel ? sram_d[15:8] : sram_d[7:0];

endmodule

// File: rtl/sram_byte_bridge.sv
// 8-bit host to 16-bit async SRAM bridge: read ack at accept+2+RD_WAIT, write ack at accept+3+WR_WAIT.
// req is sampled only in IDLE; SRAM_BRIDGE_POSTED_WRITE_EN acks writes in SETUP and skips DONE.
module sram_byte_bridge
    import sram_bridge_pkg::*;
#(
    parameter int RD_WAIT = 2,
    parameter int WR_WAIT = 2
) (
    input  logic        clk_chipset,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [20:0] addr,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        ack,
    output logic        busy,
    output logic [18:0] SRAM_A,
    inout  wire  [15:0] SRAM_D,
    output logic [3:0]  SRAM_CE_n,
    output logic        SRAM_OE_n,
    output logic        SRAM_WE_n
);

`ifdef SRAM_BRIDGE_POSTED_WRITE_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    localparam int RD_EFF = (RD_WAIT < 1) ? 1 : ((RD_WAIT > MAX_WAIT) ? MAX_WAIT : RD_WAIT);
    localparam int WR_EFF = (WR_WAIT < 1) ? 1 : ((WR_WAIT > MAX_WAIT) ? MAX_WAIT : WR_WAIT);
    localparam logic [3:0] RD_LOAD = 4'(RD_EFF - 1);
    localparam logic [3:0] WR_LOAD = 4'(WR_EFF - 1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nxt;
    logic        accept;
    logic        capture;

    logic [20:0] addr_q;
    logic        we_q;
    logic [7:0]  wdata_q;
    logic [7:0]  rdata_q;
    logic [7:0]  lane_rd;
    logic [1:0]  bank;
    logic        ce_act;
    logic        lane_drive;

    always_ff @(posedge clk_chipset or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        capture   = 1'b0;
        unique case (state)
            IDLE: begin
                if (req) begin
                    accept    = 1'b1;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                state_nxt = we_q ? WR : RD;
                cnt_nxt   = we_q ? WR_LOAD : RD_LOAD;
            end
            RD: begin
                if (cnt == 4'd0) begin
                    capture   = 1'b1;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            WR: begin
                if (cnt == 4'd0) begin
                    state_nxt = HOLD;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            // A posted write was already acknowledged in SETUP, so DONE is skipped.
            HOLD:    state_nxt = POSTED ? IDLE : DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_chipset or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                addr_q  <= addr;
                we_q    <= we;
                wdata_q <= wdata;
            end
            if (capture) begin
                rdata_q <= lane_rd;
            end
        end
    end

    assign bank       = addr_q[20:19];
    assign ce_act     = (state == SETUP) || (state == RD) || (state == WR) || (state == HOLD);
    assign lane_drive = we_q && ((state == SETUP) || (state == WR) || (state == HOLD));

    assign SRAM_A    = addr_q[18:0];
    assign SRAM_CE_n = ce_act ? ~(4'b0001 << bank) : 4'hF;
    assign SRAM_OE_n = (state != RD);
    assign SRAM_WE_n = (state != WR);

    assign ack   = (state == DONE) || (POSTED && (state == SETUP) && we_q);
    assign busy  = (state != IDLE);
    assign rdata = rdata_q;

    sram_lane_io u_lane_io (
        .lane_sel (lane_hi(bank)),
        .drive    (lane_drive),
        .wr_byte  (wdata_q),
        .rd_byte  (lane_rd),
        .sram_d   (SRAM_D)
    );

endmodule

// File: tb/tb_sram_byte_bridge.sv
// Bench for sram_byte_bridge: async SRAM model, byte-level reference memory, default and swept-parameter instances.
module tb_sram_byte_bridge;

    localparam int RD_W = 2;
    localparam int WR_W = 2;
    localparam int RD_S = 1;
    localparam int WR_S = 5;
`ifdef SRAM_BRIDGE_POSTED_WRITE_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        req, we;
    logic [20:0] addr;
    logic [7:0]  wdata, rdata;
    logic        ack, busy;
    logic [18:0] SRAM_A;
    wire  [15:0] sram_d;
    logic [3:0]  SRAM_CE_n;
    logic        SRAM_OE_n, SRAM_WE_n;

    logic        req_s, we_s;
    logic [20:0] addr_s;
    logic [7:0]  wdata_s, rdata_s;
    logic        ack_s, busy_s;
    logic [18:0] a_s;
    wire  [15:0] d_s;
    logic [3:0]  ce_s;
    logic        oe_s_n, we_s_n;

    int n_tests;
    int n_fail;

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    sram_byte_bridge #(.RD_WAIT(RD_W), .WR_WAIT(WR_W)) dut (
        .clk_chipset(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ack(ack), .busy(busy), .SRAM_A(SRAM_A), .SRAM_D(sram_d),
        .SRAM_CE_n(SRAM_CE_n), .SRAM_OE_n(SRAM_OE_n), .SRAM_WE_n(SRAM_WE_n)
    );

    sram_byte_bridge #(.RD_WAIT(RD_S), .WR_WAIT(WR_S)) dut_s (
        .clk_chipset(clk), .rst_n(rst_n), .req(req_s), .we(we_s), .addr(addr_s), .wdata(wdata_s),
        .rdata(rdata_s), .ack(ack_s), .busy(busy_s), .SRAM_A(a_s), .SRAM_D(d_s),
        .SRAM_CE_n(ce_s), .SRAM_OE_n(oe_s_n), .SRAM_WE_n(we_s_n)
    );

    // Board memory: four 16-bit chips, word key = {chip, A}; unwritten words follow a seeded pattern.
    function automatic logic [15:0] init_word(input logic [20:0] k);
        logic [31:0] h;
        if (k == 21'h000012) return 16'hA55A;
        h = {11'd0, k} * 32'h9E3779B1;
        return h[31:16];
    endfunction

    logic [15:0] mem [logic [20:0]];
    logic [7:0]  ref_mem [logic [20:0]];
    logic        drv_en = 1'b0;
    logic [15:0] drv_word = 16'h0;
    logic        m_sel;
    logic [1:0]  m_chip;
    logic [20:0] m_key;
    logic [15:0] m_word;

    assign sram_d = drv_en ? drv_word : 16'hzzzz;

    always @(negedge clk) begin
        m_sel  = 1'b1;
        m_chip = 2'd0;
        case (SRAM_CE_n)
            4'b1110: m_chip = 2'd0;
            4'b1101: m_chip = 2'd1;
            4'b1011: m_chip = 2'd2;
            4'b0111: m_chip = 2'd3;
            default: m_sel = 1'b0;
        endcase
        m_key  = {m_chip, SRAM_A};
        m_word = mem.exists(m_key) ? mem[m_key] : init_word(m_key);
        if (m_sel && !SRAM_WE_n) begin
            if (m_chip[0]) m_word[15:8] = sram_d[15:8];
            else           m_word[7:0]  = sram_d[7:0];
            mem[m_key] = m_word;
        end
        drv_en   <= m_sel && !SRAM_OE_n && SRAM_WE_n;
        drv_word <= m_word;
    end

    // Host-visible meaning of a byte address, independent of how the bridge sequences it.
    function automatic logic [7:0] ref_read(input logic [20:0] a);
        logic [15:0] w;
        if (ref_mem.exists(a)) return ref_mem[a];
        w = init_word(a);
        return a[19] ? w[15:8] : w[7:0];
    endfunction

    typedef struct packed {
        logic [3:0]  ce;
        logic [18:0] a;
        logic [15:0] d;
        logic        we_n;
    } bus_t;

    bus_t log_q[$];
    int cyc = 0;
    int acc_cyc = 0;
    int acc_s_cyc = 0;
    int oe_tot = 0;
    int we_tot = 0;
    int ack_tot = 0;
    int multi_ce = 0;
    int oe_s_tot = 0;
    int we_s_tot = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && req && !busy)     acc_cyc   <= cyc;
        if (rst_n && req_s && !busy_s) acc_s_cyc <= cyc;
    end

    always @(negedge clk) begin
        if (!SRAM_OE_n) oe_tot <= oe_tot + 1;
        if (!SRAM_WE_n) we_tot <= we_tot + 1;
        if (ack)        ack_tot <= ack_tot + 1;
        if ($countones(~SRAM_CE_n) > 1) multi_ce <= multi_ce + 1;
        if (!oe_s_n)    oe_s_tot <= oe_s_tot + 1;
        if (!we_s_n)    we_s_tot <= we_s_tot + 1;
        if (SRAM_CE_n != 4'hF) log_q.push_back({SRAM_CE_n, SRAM_A, sram_d, SRAM_WE_n});
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog");
    end

    task automatic run_acc(input logic w, input logic [20:0] a, input logic [7:0] d, output int lat);
        bit got;
        @(posedge clk); #1;
        req = 1'b1; we = w; addr = a; wdata = d;
        got = 1'b0;
        lat = -1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (ack) begin
                got = 1'b1;
                lat = cyc - acc_cyc;
                req = 1'b0;
            end
        end
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
        #1;
        req = 1'b0;
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL ack_timeout addr=%h: no ack within 40 cycles, required one", a);
        end
        if (w) ref_mem[a] = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests += 8;
        if (SRAM_CE_n !== 4'hF) begin n_fail++; $display("FAIL reset_ce got=%h exp=f", SRAM_CE_n); end
        if (SRAM_OE_n !== 1'b1) begin n_fail++; $display("FAIL reset_oe got=%b exp=1", SRAM_OE_n); end
        if (SRAM_WE_n !== 1'b1) begin n_fail++; $display("FAIL reset_we got=%b exp=1", SRAM_WE_n); end
        if (SRAM_A !== 19'h0)   begin n_fail++; $display("FAIL reset_a got=%h exp=0", SRAM_A); end
        if (ack !== 1'b0)       begin n_fail++; $display("FAIL reset_ack got=%b exp=0", ack); end
        if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (rdata !== 8'h00)    begin n_fail++; $display("FAIL reset_rdata got=%h exp=00", rdata); end
        if (ce_s !== 4'hF)      begin n_fail++; $display("FAIL reset_ce_sweep got=%h exp=f", ce_s); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_read();
        int lat, n0, oe0;
        n0 = log_q.size();
        oe0 = oe_tot;
        run_acc(1'b0, 21'h000012, 8'h00, lat);
        n_tests += 4;
        if (lat != 2 + RD_W) begin n_fail++; $display("FAIL read_latency got=%0d exp=%0d", lat, 2 + RD_W); end
        if (rdata !== 8'h5A) begin n_fail++; $display("FAIL read_data got=%h exp=5a", rdata); end
        if (oe_tot - oe0 != RD_W) begin n_fail++; $display("FAIL read_oe_cycles got=%0d exp=%0d", oe_tot - oe0, RD_W); end
        if (log_q.size() - n0 != 1 + RD_W) begin
            n_fail++;
            $display("FAIL read_ce_cycles got=%0d exp=%0d", log_q.size() - n0, 1 + RD_W);
        end else begin
            n_tests += 2;
            if (log_q[n0].ce !== 4'b1110) begin n_fail++; $display("FAIL read_ce got=%b exp=1110", log_q[n0].ce); end
            if (log_q[n0].a !== 19'h00012) begin n_fail++; $display("FAIL read_addr got=%h exp=00012", log_q[n0].a); end
        end
    endtask

    task automatic test_write();
        int lat, n0, we0, n, bad;
        logic [20:0] a;
        logic [18:0] a_lo;
        logic        exp_wen;
        a = 21'h1ABCDE;
        a_lo = a[18:0];
        n0 = log_q.size();
        we0 = we_tot;
        run_acc(1'b1, a, 8'h3C, lat);
        n = log_q.size() - n0;
        n_tests += 3;
        if (lat != (POSTED ? 1 : 3 + WR_W)) begin
            n_fail++;
            $display("FAIL write_latency got=%0d exp=%0d", lat, POSTED ? 1 : 3 + WR_W);
        end
        if (we_tot - we0 != WR_W) begin n_fail++; $display("FAIL write_we_cycles got=%0d exp=%0d", we_tot - we0, WR_W); end
        if (n != WR_W + 2) begin
            n_fail++;
            $display("FAIL write_ce_cycles got=%0d exp=%0d", n, WR_W + 2);
        end else begin
            bad = 0;
            for (int i = 0; i < n; i++) begin
                exp_wen = (i == 0) || (i == n - 1);
                if (log_q[n0 + i].we_n !== exp_wen) bad++;
                if (log_q[n0 + i].d[15:8] !== 8'h3C) bad++;
            end
            n_tests += 3;
            if (log_q[n0].ce !== 4'b0111) begin n_fail++; $display("FAIL write_ce got=%b exp=0111", log_q[n0].ce); end
            if (log_q[n0].a !== a_lo) begin n_fail++; $display("FAIL write_addr got=%h exp=%h", log_q[n0].a, a_lo); end
            if (bad != 0) begin n_fail++; $display("FAIL write_we_data_window got=%0d bad cycles exp=0", bad); end
        end
        run_acc(1'b0, a, 8'h00, lat);
        n_tests++;
        if (rdata !== 8'h3C) begin n_fail++; $display("FAIL write_readback got=%h exp=3c", rdata); end
    endtask

    task automatic test_back_to_back();
        logic [20:0] a1, a2;
        logic [7:0]  d2, rd1, exp1;
        int ack1, acc2, m0, lat;
        bit got1, got2;
        a1 = {2'b01, 19'h00034};
        a2 = {2'b10, 19'h00056};
        d2 = 8'($urandom);
        exp1 = ref_read(a1);
        m0 = multi_ce;
        got1 = 1'b0; got2 = 1'b0; ack1 = 0; acc2 = 0; rd1 = 8'h00;
        @(posedge clk); #1;
        req = 1'b1; we = 1'b0; addr = a1; wdata = 8'h00;
        for (int i = 0; i < 40 && !got1; i++) begin
            @(negedge clk);
            if (ack) begin
                got1 = 1'b1; ack1 = cyc; rd1 = rdata;
                we = 1'b1; addr = a2; wdata = d2;
            end
        end
        for (int i = 0; i < 40 && got1 && !got2; i++) begin
            @(negedge clk);
            if (ack) begin got2 = 1'b1; acc2 = acc_cyc; req = 1'b0; end
        end
        req = 1'b0;
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
        #1;
        ref_mem[a2] = d2;
        n_tests += 4;
        if (!(got1 && got2)) begin n_fail++; $display("FAIL b2b_acks got=%b%b exp=11", got1, got2); end
        if (rd1 !== exp1) begin n_fail++; $display("FAIL b2b_read got=%h exp=%h", rd1, exp1); end
        if (acc2 != ack1 + 1) begin n_fail++; $display("FAIL b2b_accept got=%0d exp=%0d", acc2, ack1 + 1); end
        if (multi_ce != m0) begin n_fail++; $display("FAIL b2b_multi_ce got=%0d exp=%0d", multi_ce - m0, 0); end
        run_acc(1'b0, a2, 8'h00, lat);
        n_tests++;
        if (rdata !== d2) begin n_fail++; $display("FAIL b2b_readback got=%h exp=%h", rdata, d2); end
    endtask

    task automatic test_random();
        logic        w;
        logic [20:0] a;
        logic [7:0]  d, exp;
        int lat, exp_lat;
        for (int i = 0; i < 40; i++) begin
            w = 1'($urandom_range(0, 1));
            a = {2'($urandom_range(0, 3)), 11'd0, 8'($urandom_range(0, 15))};
            d = 8'($urandom);
            exp = ref_read(a);
            exp_lat = w ? (POSTED ? 1 : 3 + WR_W) : 2 + RD_W;
            run_acc(w, a, d, lat);
            n_tests++;
            if (lat != exp_lat) begin n_fail++; $display("FAIL rand_latency[%0d] got=%0d exp=%0d", i, lat, exp_lat); end
            if (!w) begin
                n_tests++;
                if (rdata !== exp) begin n_fail++; $display("FAIL rand_read[%0d] addr=%h got=%h exp=%h", i, a, rdata, exp); end
            end
        end
        n_tests++;
        if (multi_ce != 0) begin n_fail++; $display("FAIL rand_multi_ce got=%0d exp=0", multi_ce); end
    endtask

    task automatic test_reset_mid_write();
        bit got;
        int ack0, lat;
        logic [20:0] a;
        logic [7:0]  exp;
        got = 1'b0;
        @(posedge clk); #1;
        req = 1'b1; we = 1'b1; addr = {2'b10, 19'h70000}; wdata = 8'hE7;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (!SRAM_WE_n) got = 1'b1;
        end
        ack0 = ack_tot;
        rst_n = 1'b0;
        req = 1'b0;
        #1;
        n_tests += 5;
        if (!got) begin n_fail++; $display("FAIL rst_mid_reach_wr got=0 exp=1"); end
        if (SRAM_WE_n !== 1'b1) begin n_fail++; $display("FAIL rst_mid_we got=%b exp=1", SRAM_WE_n); end
        if (SRAM_CE_n !== 4'hF) begin n_fail++; $display("FAIL rst_mid_ce got=%h exp=f", SRAM_CE_n); end
        if (ack !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ack_busy got=%b%b exp=00", ack, busy); end
        if (SRAM_OE_n !== 1'b1) begin n_fail++; $display("FAIL rst_mid_oe got=%b exp=1", SRAM_OE_n); end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (ack_tot != ack0) begin n_fail++; $display("FAIL rst_mid_no_ack got=%0d acks exp=0", ack_tot - ack0); end
        a = {2'b11, 19'h00009};
        exp = ref_read(a);
        run_acc(1'b0, a, 8'h00, lat);
        n_tests += 2;
        if (lat != 2 + RD_W) begin n_fail++; $display("FAIL rst_mid_after_latency got=%0d exp=%0d", lat, 2 + RD_W); end
        if (rdata !== exp) begin n_fail++; $display("FAIL rst_mid_after_read got=%h exp=%h", rdata, exp); end
    endtask

`ifdef SRAM_BRIDGE_POSTED_WRITE_EN
    task automatic test_posted();
        logic [20:0] a;
        logic [7:0]  d, rd;
        int ack_c, acc1, acc2, ack0;
        bit got1, got2;
        logic bsy;
        a = {2'b01, 19'h00077};
        d = 8'($urandom);
        got1 = 1'b0; got2 = 1'b0; ack_c = 0; acc1 = 0; acc2 = 0; bsy = 1'b0; rd = 8'h00;
        ack0 = ack_tot;
        @(posedge clk); #1;
        req = 1'b1; we = 1'b1; addr = a; wdata = d;
        for (int i = 0; i < 40 && !got1; i++) begin
            @(negedge clk);
            if (ack) begin got1 = 1'b1; ack_c = cyc; acc1 = acc_cyc; bsy = busy; we = 1'b0; end
        end
        for (int i = 0; i < 40 && got1 && !got2; i++) begin
            @(negedge clk);
            if (ack) begin got2 = 1'b1; acc2 = acc_cyc; rd = rdata; req = 1'b0; end
        end
        req = 1'b0;
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
        #1;
        ref_mem[a] = d;
        n_tests += 5;
        if (ack_c - acc1 != 1) begin n_fail++; $display("FAIL posted_ack_latency got=%0d exp=1", ack_c - acc1); end
        if (bsy !== 1'b1) begin n_fail++; $display("FAIL posted_busy_at_ack got=%b exp=1", bsy); end
        if (acc2 - acc1 != 3 + WR_W) begin n_fail++; $display("FAIL posted_read_accept got=%0d exp=%0d", acc2 - acc1, 3 + WR_W); end
        if (rd !== d) begin n_fail++; $display("FAIL posted_read_data got=%h exp=%h", rd, d); end
        if (ack_tot - ack0 != 2) begin n_fail++; $display("FAIL posted_ack_count got=%0d exp=2", ack_tot - ack0); end
    endtask
`endif

    task automatic test_param_sweep();
        int lat, o0, w0, exp_lat;
        bit got;
        for (int k = 0; k < 2; k++) begin
            got = 1'b0;
            lat = -1;
            o0 = oe_s_tot;
            w0 = we_s_tot;
            @(posedge clk); #1;
            req_s = 1'b1; we_s = (k == 1); addr_s = {2'b01, 19'h00005}; wdata_s = 8'hA1;
            for (int i = 0; i < 40 && !got; i++) begin
                @(negedge clk);
                if (ack_s) begin got = 1'b1; lat = cyc - acc_s_cyc; req_s = 1'b0; end
            end
            req_s = 1'b0;
            for (int i = 0; i < 20 && busy_s; i++) @(negedge clk);
            #1;
            exp_lat = (k == 1) ? (POSTED ? 1 : 3 + WR_S) : 2 + RD_S;
            n_tests += 3;
            if (lat != exp_lat) begin n_fail++; $display("FAIL sweep_latency[%0d] got=%0d exp=%0d", k, lat, exp_lat); end
            if (oe_s_tot - o0 != ((k == 1) ? 0 : RD_S)) begin
                n_fail++; $display("FAIL sweep_oe_cycles[%0d] got=%0d exp=%0d", k, oe_s_tot - o0, (k == 1) ? 0 : RD_S);
            end
            if (we_s_tot - w0 != ((k == 1) ? WR_S : 0)) begin
                n_fail++; $display("FAIL sweep_we_cycles[%0d] got=%0d exp=%0d", k, we_s_tot - w0, (k == 1) ? WR_S : 0);
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        req_s = 1'b0; we_s = 1'b0; addr_s = '0; wdata_s = '0;
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_random();
        test_reset_mid_write();
`ifdef SRAM_BRIDGE_POSTED_WRITE_EN
        test_posted();
`endif
        test_param_sweep();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
